mc_cs_cmd_arb: RTL and testbench
================================

MC_CS_CMD_ARB -- requirements
Module: mc_cs_cmd_arb

Interface
REQ-001 SHALL have parameter NUM_CS, default 8, number of chip selects arbitrated (1..8).
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port init_req  input  NUM_CS  per-CS SDRAM initialize request, level, held until acked.
REQ-005 SHALL have port lmr_req  input  NUM_CS  per-CS load-mode-register request, level, held until acked.
REQ-006 SHALL have port hold  input  1  command path busy (refresh/transfer); blocks new grants only.
REQ-007 SHALL have port init_ack  output  NUM_CS  one-hot, one-cycle completion pulse for init.
REQ-008 SHALL have port lmr_ack  output  NUM_CS  one-hot, one-cycle completion pulse for LMR.
REQ-009 SHALL have port seq_req  output  1  command request to SDRAM sequencer.
REQ-010 SHALL have port seq_init  output  1  1 = init sequence, 0 = LMR; stable while seq_req high.
REQ-011 SHALL have port seq_cs  output  3  granted CS index; stable while seq_req high.
REQ-012 SHALL have port seq_ack  input  1  sequencer completion; sampled only in GRANT.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT, DONE.
REQ-015 IDLE -> GRANT when hold low and any (init_req|lmr_req) bit set; seq_req high the following cycle.
REQ-016 Selection: any pending init beats any pending LMR; within one type, arbitration per REQ-030/031.
REQ-017 Same CS with init and LMR both pending: init served first, LMR in a later grant.
REQ-018 GRANT: seq_req, seq_init, seq_cs registered and held constant until seq_ack sampled high.
REQ-019 GRANT -> DONE on seq_ack; seq_req low in DONE.
REQ-020 DONE: exactly one of init_ack/lmr_ack bit [seq_cs] high for that one cycle; DONE -> IDLE unconditionally.
REQ-021 Minimum request-to-ack latency 3 cycles (IDLE sample, GRANT with same-cycle seq_ack, DONE).
REQ-022 Request withdrawn during GRANT: grant still completes and ack still pulses.
REQ-023 hold rising during GRANT/DONE: no effect on current command.
REQ-024 seq_ack outside GRANT: ignored.
REQ-025 Request bits at index >= NUM_CS: ignored, never granted.
REQ-026 One-cycle DONE gap guarantees requester clears req before next IDLE sample; no double grant.

Reset
REQ-027 On rst: state IDLE, seq_req 0, seq_init 0, seq_cs 0, all ack bits 0, busy 0, RR pointer 0.
REQ-028 rst mid-GRANT SHALL abort without issuing any ack; sequencer sees seq_req drop asynchronously.
REQ-029 No output SHALL depend combinationally on inputs (all registered).

Configuration
REQ-030 With MC_CS_ARB_RR_EN defined: round-robin per type, search starts at (last granted CS + 1) mod NUM_CS; pointer updates on entering DONE.
REQ-031 Without MC_CS_ARB_RR_EN: fixed priority, lowest CS index wins; no pointer state.

Structure
REQ-032 FSM state encodings and NUM_CS default SHALL live in the shared mc_defines package.
REQ-033 SHALL instantiate one sub-module mc_cs_prio_sel (request vector + start index -> valid, index), used once per type.

Verification
REQ-034 init_req=8'h04, seq_ack 2 cycles after seq_req -> seq_cs=2, seq_init=1, init_ack=8'h04 one cycle, busy low after.
REQ-035 init_req=8'h01, lmr_req=8'h80 same cycle -> first grant CS0 init, second grant CS7 LMR.
REQ-036 RR_EN, lmr_req=8'h0A held, acks each grant -> grant order CS1, CS3, CS1; without RR_EN -> CS1, CS1, CS1.
REQ-037 hold=1 with init_req=8'h10 -> no seq_req; hold drops -> seq_req next cycle, seq_cs=4.
REQ-038 rst pulsed while GRANT -> seq_req 0 immediately, no ack pulse, IDLE; pending req re-granted after release.
REQ-039 NUM_CS=4, lmr_req=8'hF0 -> seq_req never asserts, busy stays 0.

Source files
------------

// File: rtl/mc_defines.sv
// Shared definitions for the memory-controller chip-select command arbiter:
// default chip-select count, FSM state encodings and a pointer helper.
package mc_defines;

    localparam int MC_NUM_CS_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_e;

    // (idx + 1) mod n, for n in 1..8
    function automatic logic [2:0] next_idx(input logic [2:0] idx,
                                            input int n);
        int t;
        t = int'(idx) + 1;
        if (t >= n) t = 0;
        return 3'(t);
    endfunction

endpackage

// File: rtl/mc_cs_prio_sel.sv
// Circular priority selector: first set bit of req found searching upward
// from start (wrapping at N).
// Ports: req_i request vector, start_i search origin, valid_o any hit,
//        idx_o index of the selected bit.
module mc_cs_prio_sel #(
    parameter int N = 8
) (
    input  logic [N-1:0] req_i,
    input  logic [2:0]   start_i,
    output logic         valid_o,
    output logic [2:0]   idx_o
);

    int k;

    // Walk offsets from highest to lowest so the smallest offset from
    // start_i is the last one written and therefore wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = 3'd0;
        k       = 0;
        for (int i = N - 1; i >= 0; i--) begin
            k = (int'(start_i) + i) % N;
            if (req_i[k]) begin
                valid_o = 1'b1;
                idx_o   = 3'(k);
            end
        end
    end

endmodule

// File: rtl/mc_cs_cmd_arb.sv
// Arbitrates per-chip-select init / load-mode-register requests onto a
// single SDRAM sequencer command port (IDLE -> GRANT -> DONE).
// Ports: clk, rst (async, active-high); init_req/lmr_req level requests;
//        hold blocks new grants; init_ack/lmr_ack one-cycle pulses;
//        seq_req/seq_init/seq_cs to sequencer, seq_ack back; busy.
// Build option: define MC_CS_ARB_RR_EN for per-type round-robin,
// otherwise fixed priority (lowest CS index wins).
module mc_cs_cmd_arb
    import mc_defines::*;
#(
    parameter int NUM_CS = MC_NUM_CS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CS-1:0] init_req,
    input  logic [NUM_CS-1:0] lmr_req,
    input  logic              hold,
    output logic [NUM_CS-1:0] init_ack,
    output logic [NUM_CS-1:0] lmr_ack,
    output logic              seq_req,
    output logic              seq_init,
    output logic [2:0]        seq_cs,
    input  logic              seq_ack,
    output logic              busy
);

    arb_state_e        state_q;
    logic              seq_req_q;
    logic              seq_init_q;
    logic [2:0]        seq_cs_q;
    logic [NUM_CS-1:0] init_ack_q;
    logic [NUM_CS-1:0] lmr_ack_q;
    logic              busy_q;

    logic              i_vld;
    logic              l_vld;
    logic [2:0]        i_idx;
    logic [2:0]        l_idx;
    logic [2:0]        i_start;
    logic [2:0]        l_start;

`ifdef MC_CS_ARB_RR_EN
    // Pointers hold the next search origin per request type.
    logic [2:0] i_ptr_q;
    logic [2:0] l_ptr_q;
    assign i_start = i_ptr_q;
    assign l_start = l_ptr_q;
`else
    assign i_start = 3'd0;
    assign l_start = 3'd0;
`endif

    mc_cs_prio_sel #(.N(NUM_CS)) u_sel_init (
        .req_i   (init_req),
        .start_i (i_start),
        .valid_o (i_vld),
        .idx_o   (i_idx)
    );

    mc_cs_prio_sel #(.N(NUM_CS)) u_sel_lmr (
        .req_i   (lmr_req),
        .start_i (l_start),
        .valid_o (l_vld),
        .idx_o   (l_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            seq_req_q  <= 1'b0;
            seq_init_q <= 1'b0;
            seq_cs_q   <= 3'd0;
            init_ack_q <= '0;
            lmr_ack_q  <= '0;
            busy_q     <= 1'b0;
`ifdef MC_CS_ARB_RR_EN
            i_ptr_q    <= 3'd0;
            l_ptr_q    <= 3'd0;
`endif
        end else begin
            init_ack_q <= '0;
            lmr_ack_q  <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (!hold && (i_vld || l_vld)) begin
                        state_q    <= ST_GRANT;
                        seq_req_q  <= 1'b1;
                        seq_init_q <= i_vld;
                        seq_cs_q   <= i_vld ? i_idx : l_idx;
                        busy_q     <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (seq_ack) begin
                        state_q   <= ST_DONE;
                        seq_req_q <= 1'b0;
                        if (seq_init_q)
                            init_ack_q <= NUM_CS'(1) << seq_cs_q;
                        else
                            lmr_ack_q  <= NUM_CS'(1) << seq_cs_q;
`ifdef MC_CS_ARB_RR_EN
                        if (seq_init_q)
                            i_ptr_q <= next_idx(seq_cs_q, NUM_CS);
                        else
                            l_ptr_q <= next_idx(seq_cs_q, NUM_CS);
`endif
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign seq_req  = seq_req_q;
    assign seq_init = seq_init_q;
    assign seq_cs   = seq_cs_q;
    assign init_ack = init_ack_q;
    assign lmr_ack  = lmr_ack_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mc_cs_cmd_arb.sv
// Directed bench for mc_cs_cmd_arb: an 8-CS instance for the main
// scenarios and a 4-CS instance for out-of-range request bits.
module tb_mc_cs_cmd_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] init_req = '0;
    logic [7:0] lmr_req = '0;
    logic       hold = 1'b0;
    logic       seq_ack = 1'b0;
    logic [7:0] init_ack;
    logic [7:0] lmr_ack;
    logic       seq_req;
    logic       seq_init;
    logic [2:0] seq_cs;
    logic       busy;

    logic [3:0] init_req4 = '0;
    logic [3:0] lmr_req4 = '0;
    logic [3:0] init_ack4;
    logic [3:0] lmr_ack4;
    logic       seq_req4;
    logic       seq_init4;
    logic [2:0] seq_cs4;
    logic       busy4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mc_cs_cmd_arb #(.NUM_CS(8)) dut (
        .clk(clk), .rst(rst),
        .init_req(init_req), .lmr_req(lmr_req), .hold(hold),
        .init_ack(init_ack), .lmr_ack(lmr_ack),
        .seq_req(seq_req), .seq_init(seq_init), .seq_cs(seq_cs),
        .seq_ack(seq_ack), .busy(busy)
    );

    mc_cs_cmd_arb #(.NUM_CS(4)) dut4 (
        .clk(clk), .rst(rst),
        .init_req(init_req4), .lmr_req(lmr_req4), .hold(hold),
        .init_ack(init_ack4), .lmr_ack(lmr_ack4),
        .seq_req(seq_req4), .seq_init(seq_init4), .seq_cs(seq_cs4),
        .seq_ack(seq_ack), .busy(busy4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for a grant, acks it in the same cycle and
    // returns the granted command plus the ack vectors seen in DONE.
    task automatic serve(output logic [2:0] cs, output logic ini,
                         output logic [7:0] ia, output logic [7:0] la,
                         output bit ok);
        for (int i = 0; i < 20 && !seq_req; i++) tick();
        ok  = seq_req;
        cs  = seq_cs;
        ini = seq_init;
        seq_ack = 1'b1;
        tick();
        ia = init_ack;
        la = lmr_ack;
        seq_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (seq_req !== 1'b0 || seq_init !== 1'b0 || seq_cs !== 3'd0) begin
            failures++;
            $display("FAIL reset_seq got=%b%b%0d exp=000", seq_req, seq_init, seq_cs);
        end
        checks++;
        if (init_ack !== 8'h00 || lmr_ack !== 8'h00) begin
            failures++;
            $display("FAIL reset_ack got=%h/%h exp=00/00", init_ack, lmr_ack);
        end
        checks++;
        if (busy !== 1'b0 || busy4 !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b%b exp=00", busy, busy4);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        init_req = 8'h04;
        tick();
        checks++;
        if (seq_req !== 1'b1 || seq_cs !== 3'd2 || seq_init !== 1'b1) begin
            failures++;
            $display("FAIL basic_grant got=%b/%0d/%b exp=1/2/1", seq_req, seq_cs, seq_init);
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy got=%b exp=1", busy);
        end
        tick();
        checks++;
        if (seq_req !== 1'b1 || seq_cs !== 3'd2 || init_ack !== 8'h00) begin
            failures++;
            $display("FAIL basic_hold got=%b/%0d/%h exp=1/2/00", seq_req, seq_cs, init_ack);
        end
        seq_ack = 1'b1;
        tick();
        seq_ack = 1'b0;
        init_req = 8'h00;
        checks++;
        if (init_ack !== 8'h04 || lmr_ack !== 8'h00 || seq_req !== 1'b0) begin
            failures++;
            $display("FAIL basic_ack got=%h/%h/%b exp=04/00/0", init_ack, lmr_ack, seq_req);
        end
        tick();
        checks++;
        if (init_ack !== 8'h00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_done got=%h/%b exp=00/0", init_ack, busy);
        end
        tick();
        checks++;
        if (seq_req !== 1'b0) begin
            failures++;
            $display("FAIL basic_no_regrant got=%b exp=0", seq_req);
        end
    endtask

    task automatic test_init_over_lmr();
        logic [2:0] cs;
        logic ini;
        logic [7:0] ia, la;
        bit ok;
        init_req = 8'h01;
        lmr_req = 8'h80;
        serve(cs, ini, ia, la, ok);
        init_req = 8'h00;
        checks++;
        if (!ok || cs !== 3'd0 || ini !== 1'b1 || ia !== 8'h01 || la !== 8'h00) begin
            failures++;
            $display("FAIL prio_first got=%b/%0d/%b/%h/%h exp=1/0/1/01/00", ok, cs, ini, ia, la);
        end
        serve(cs, ini, ia, la, ok);
        lmr_req = 8'h00;
        checks++;
        if (!ok || cs !== 3'd7 || ini !== 1'b0 || ia !== 8'h00 || la !== 8'h80) begin
            failures++;
            $display("FAIL prio_second got=%b/%0d/%b/%h/%h exp=1/7/0/00/80", ok, cs, ini, ia, la);
        end
        tick();
    endtask

    task automatic test_same_cs();
        logic [2:0] cs;
        logic ini;
        logic [7:0] ia, la;
        bit ok;
        init_req = 8'h08;
        lmr_req = 8'h08;
        serve(cs, ini, ia, la, ok);
        init_req = 8'h00;
        checks++;
        if (!ok || cs !== 3'd3 || ini !== 1'b1 || ia !== 8'h08) begin
            failures++;
            $display("FAIL same_init got=%b/%0d/%b/%h exp=1/3/1/08", ok, cs, ini, ia);
        end
        serve(cs, ini, ia, la, ok);
        lmr_req = 8'h00;
        checks++;
        if (!ok || cs !== 3'd3 || ini !== 1'b0 || la !== 8'h08) begin
            failures++;
            $display("FAIL same_lmr got=%b/%0d/%b/%h exp=1/3/0/08", ok, cs, ini, la);
        end
        tick();
    endtask

    task automatic test_arb_order();
        logic [2:0] cs;
        logic ini;
        logic [7:0] ia, la;
        bit ok;
        logic [2:0] exp_cs [3];
`ifdef MC_CS_ARB_RR_EN
        exp_cs = '{3'd1, 3'd3, 3'd1};
`else
        exp_cs = '{3'd1, 3'd1, 3'd1};
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        lmr_req = 8'h0A;
        for (int n = 0; n < 3; n++) begin
            serve(cs, ini, ia, la, ok);
            checks++;
            if (!ok || cs !== exp_cs[n] || ini !== 1'b0 || la !== (8'h01 << exp_cs[n])) begin
                failures++;
                $display("FAIL arb_order[%0d] got=%b/%0d/%b/%h exp=1/%0d/0", n, ok, cs, ini, la, exp_cs[n]);
            end
        end
        lmr_req = 8'h00;
        tick();
    endtask

    task automatic test_hold();
        hold = 1'b1;
        init_req = 8'h10;
        for (int n = 0; n < 4; n++) begin
            tick();
            checks++;
            if (seq_req !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL hold_block[%0d] got=%b/%b exp=0/0", n, seq_req, busy);
            end
        end
        hold = 1'b0;
        tick();
        checks++;
        if (seq_req !== 1'b1 || seq_cs !== 3'd4 || seq_init !== 1'b1) begin
            failures++;
            $display("FAIL hold_release got=%b/%0d/%b exp=1/4/1", seq_req, seq_cs, seq_init);
        end
        hold = 1'b1;
        seq_ack = 1'b1;
        tick();
        seq_ack = 1'b0;
        init_req = 8'h00;
        checks++;
        if (init_ack !== 8'h10 || seq_req !== 1'b0) begin
            failures++;
            $display("FAIL hold_in_grant got=%h/%b exp=10/0", init_ack, seq_req);
        end
        hold = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_ack_outside_and_withdraw();
        seq_ack = 1'b1;
        tick();
        tick();
        seq_ack = 1'b0;
        checks++;
        if (busy !== 1'b0 || init_ack !== 8'h00 || lmr_ack !== 8'h00) begin
            failures++;
            $display("FAIL stray_ack got=%b/%h/%h exp=0/00/00", busy, init_ack, lmr_ack);
        end
        lmr_req = 8'h02;
        tick();
        lmr_req = 8'h00;
        tick();
        checks++;
        if (seq_req !== 1'b1 || seq_cs !== 3'd1 || seq_init !== 1'b0) begin
            failures++;
            $display("FAIL withdraw_hold got=%b/%0d/%b exp=1/1/0", seq_req, seq_cs, seq_init);
        end
        seq_ack = 1'b1;
        tick();
        seq_ack = 1'b0;
        checks++;
        if (lmr_ack !== 8'h02 || init_ack !== 8'h00) begin
            failures++;
            $display("FAIL withdraw_ack got=%h/%h exp=02/00", lmr_ack, init_ack);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid_grant();
        init_req = 8'h20;
        tick();
        checks++;
        if (seq_req !== 1'b1 || seq_cs !== 3'd5) begin
            failures++;
            $display("FAIL rstg_grant got=%b/%0d exp=1/5", seq_req, seq_cs);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (seq_req !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstg_async got=%b/%b exp=0/0", seq_req, busy);
        end
        seq_ack = 1'b1;
        tick();
        seq_ack = 1'b0;
        checks++;
        if (init_ack !== 8'h00 || lmr_ack !== 8'h00) begin
            failures++;
            $display("FAIL rstg_no_ack got=%h/%h exp=00/00", init_ack, lmr_ack);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (seq_req !== 1'b1 || seq_cs !== 3'd5 || seq_init !== 1'b1) begin
            failures++;
            $display("FAIL rstg_regrant got=%b/%0d/%b exp=1/5/1", seq_req, seq_cs, seq_init);
        end
        seq_ack = 1'b1;
        tick();
        seq_ack = 1'b0;
        init_req = 8'h00;
        checks++;
        if (init_ack !== 8'h20) begin
            failures++;
            $display("FAIL rstg_ack got=%h exp=20", init_ack);
        end
        tick();
        tick();
    endtask

    task automatic test_num_cs4();
        logic [7:0] wide;
        wide = 8'hF0;
        lmr_req4 = wide[3:0];
        init_req4 = 4'h0;
        for (int n = 0; n < 4; n++) begin
            tick();
            checks++;
            if (seq_req4 !== 1'b0 || busy4 !== 1'b0) begin
                failures++;
                $display("FAIL cs4_ignore[%0d] got=%b/%b exp=0/0", n, seq_req4, busy4);
            end
        end
        lmr_req4 = 4'h8;
        tick();
        checks++;
        if (seq_req4 !== 1'b1 || seq_cs4 !== 3'd3 || seq_init4 !== 1'b0) begin
            failures++;
            $display("FAIL cs4_grant got=%b/%0d/%b exp=1/3/0", seq_req4, seq_cs4, seq_init4);
        end
        seq_ack = 1'b1;
        tick();
        seq_ack = 1'b0;
        lmr_req4 = 4'h0;
        checks++;
        if (lmr_ack4 !== 4'h8 || init_ack4 !== 4'h0) begin
            failures++;
            $display("FAIL cs4_ack got=%h/%h exp=8/0", lmr_ack4, init_ack4);
        end
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_init_over_lmr();
        test_same_cs();
        test_arb_order();
        test_hold();
        test_ack_outside_and_withdraw();
        test_reset_mid_grant();
        test_num_cs4();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
